// File: rtl/score_req_scheduler.sv
// Shares one score tracker between N player stations: latches one submission per station,
// issues them round-robin once the tracker's RAM clear is done, and routes results or timeouts back.
//
// state        | meaning
// -------------|---------------------------------------------------------------
// S_INIT_HOLD  | waiting out the tracker's post-reset RAM clear, no requests
// S_IDLE       | tracker free, grant the next pending station round-robin
// S_WAIT_VALID | request issued to station ptr_q, waiting for valid or timeout
module score_req_scheduler #(
    parameter int N           = 4,
    parameter int INIT_CYCLES = 36,
    parameter int TIMEOUT     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     sub_req,
    input  logic [7*N-1:0]   sub_score,
    input  logic [3*N-1:0]   sub_id,
    input  logic [N-1:0]     sub_guest,
    output logic [N-1:0]     sub_ack,
    output logic [N-1:0]     sub_done,
    output logic [N-1:0]     sub_pw,
    output logic [N-1:0]     sub_gw,
    output logic [N-1:0]     sub_tmo,
    output logic             score_req,
    output logic [6:0]       score,
    output logic [2:0]       playerID,
    output logic             isGuest,
    input  logic             valid,
    input  logic             personal_winner,
    input  logic             global_winner,
    output logic             ready
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam int IW = $clog2(INIT_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_INIT_HOLD  = 2'd0,
        S_IDLE       = 2'd1,
        S_WAIT_VALID = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [N-1:0]          pend_q, pend_d;
    logic [N-1:0][6:0]     lat_score_q, lat_score_d;
    logic [N-1:0][2:0]     lat_id_q, lat_id_d;
    logic [N-1:0]          lat_guest_q, lat_guest_d;
    logic [PW-1:0]         ptr_q, ptr_d;
    logic [IW-1:0]         init_cnt_q, init_cnt_d;
    logic [TW-1:0]         tmo_cnt_q, tmo_cnt_d;
    logic [N-1:0]          sub_ack_q, sub_ack_d;
    logic [N-1:0]          sub_done_q, sub_done_d;
    logic [N-1:0]          sub_pw_q, sub_pw_d;
    logic [N-1:0]          sub_gw_q, sub_gw_d;
    logic [N-1:0]          sub_tmo_q, sub_tmo_d;
    logic                  score_req_q, score_req_d;
    logic [6:0]            score_q, score_d;
    logic [2:0]            player_id_q, player_id_d;
    logic                  is_guest_q, is_guest_d;
    logic                  ready_q, ready_d;

    logic                  grant_found;
    logic [PW-1:0]         grant_idx;
    logic [PW-1:0]         cand;

    // First pending station strictly after the last grant, wrapping modulo N.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 1; k <= N; k++) begin
            cand = PW'((int'(ptr_q) + k) % N);
            if (!grant_found && pend_q[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        pend_d      = pend_q;
        lat_score_d = lat_score_q;
        lat_id_d    = lat_id_q;
        lat_guest_d = lat_guest_q;
        ptr_d       = ptr_q;
        init_cnt_d  = init_cnt_q;
        tmo_cnt_d   = tmo_cnt_q;
        sub_ack_d   = '0;
        sub_done_d  = '0;
        sub_pw_d    = sub_pw_q;
        sub_gw_d    = sub_gw_q;
        sub_tmo_d   = sub_tmo_q;
        score_req_d = 1'b0;
        score_d     = score_q;
        player_id_d = player_id_q;
        is_guest_d  = is_guest_q;

        case (state_q)
            S_INIT_HOLD: begin
                if (init_cnt_q == IW'(INIT_CYCLES - 1)) begin
                    state_d = S_IDLE;
                end else begin
                    init_cnt_d = init_cnt_q + 1'b1;
                end
            end
            S_IDLE: begin
                if (grant_found) begin
                    ptr_d       = grant_idx;
                    score_d     = lat_score_q[grant_idx];
                    player_id_d = lat_id_q[grant_idx];
                    is_guest_d  = lat_guest_q[grant_idx];
                    score_req_d = 1'b1;
                    tmo_cnt_d   = '0;
                    state_d     = S_WAIT_VALID;
                end
            end
            S_WAIT_VALID: begin
                if (valid) begin
                    sub_pw_d[ptr_q]   = personal_winner;
                    sub_gw_d[ptr_q]   = global_winner;
                    sub_tmo_d[ptr_q]  = 1'b0;
                    sub_done_d[ptr_q] = 1'b1;
                    pend_d[ptr_q]     = 1'b0;
                    state_d           = S_IDLE;
                end else if (tmo_cnt_q == TW'(TIMEOUT - 1)) begin
                    sub_pw_d[ptr_q]   = 1'b0;
                    sub_gw_d[ptr_q]   = 1'b0;
                    sub_tmo_d[ptr_q]  = 1'b1;
                    sub_done_d[ptr_q] = 1'b1;
                    pend_d[ptr_q]     = 1'b0;
                    state_d           = S_IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
            default: state_d = S_INIT_HOLD;
        endcase

        // Capture only looks at the registered pend bit, so a station whose request
        // completes on this edge is still seen as busy and its strobe is dropped.
        for (int i = 0; i < N; i++) begin
            if (sub_req[i] && !pend_q[i]) begin
                pend_d[i]      = 1'b1;
                lat_score_d[i] = sub_score[7*i +: 7];
                lat_id_d[i]    = sub_id[3*i +: 3];
                lat_guest_d[i] = sub_guest[i];
                sub_ack_d[i]   = 1'b1;
            end
        end

        ready_d = (state_d == S_IDLE) || (state_d == S_WAIT_VALID);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_INIT_HOLD;
            pend_q      <= '0;
            lat_score_q <= '0;
            lat_id_q    <= '0;
            lat_guest_q <= '0;
            ptr_q       <= PW'(N - 1);
            init_cnt_q  <= '0;
            tmo_cnt_q   <= '0;
            sub_ack_q   <= '0;
            sub_done_q  <= '0;
            sub_pw_q    <= '0;
            sub_gw_q    <= '0;
            sub_tmo_q   <= '0;
            score_req_q <= 1'b0;
            score_q     <= '0;
            player_id_q <= '0;
            is_guest_q  <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            lat_score_q <= lat_score_d;
            lat_id_q    <= lat_id_d;
            lat_guest_q <= lat_guest_d;
            ptr_q       <= ptr_d;
            init_cnt_q  <= init_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
            sub_ack_q   <= sub_ack_d;
            sub_done_q  <= sub_done_d;
            sub_pw_q    <= sub_pw_d;
            sub_gw_q    <= sub_gw_d;
            sub_tmo_q   <= sub_tmo_d;
            score_req_q <= score_req_d;
            score_q     <= score_d;
            player_id_q <= player_id_d;
            is_guest_q  <= is_guest_d;
            ready_q     <= ready_d;
        end
    end

    assign sub_ack   = sub_ack_q;
    assign sub_done  = sub_done_q;
    assign sub_pw    = sub_pw_q;
    assign sub_gw    = sub_gw_q;
    assign sub_tmo   = sub_tmo_q;
    assign score_req = score_req_q;
    assign score     = score_q;
    assign playerID  = player_id_q;
    assign isGuest   = is_guest_q;
    assign ready     = ready_q;

endmodule

// File: tb/tb_score_req_scheduler.sv
// Directed bench for score_req_scheduler: an event-level model of the scheduler is compared
// against the DUT every cycle, plus hand-computed latency and result expectations.
module tb_score_req_scheduler;

    localparam int N           = 4;
    localparam int INIT_CYCLES = 36;
    localparam int TIMEOUT     = 16;

    logic             clk;
    logic             rst;
    logic [N-1:0]     sub_req;
    logic [7*N-1:0]   sub_score;
    logic [3*N-1:0]   sub_id;
    logic [N-1:0]     sub_guest;
    logic [N-1:0]     sub_ack, sub_done, sub_pw, sub_gw, sub_tmo;
    logic             score_req;
    logic [6:0]       score;
    logic [2:0]       playerID;
    logic             isGuest;
    logic             valid, personal_winner, global_winner;
    logic             ready;

    score_req_scheduler #(.N(N), .INIT_CYCLES(INIT_CYCLES), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .sub_req(sub_req), .sub_score(sub_score), .sub_id(sub_id), .sub_guest(sub_guest),
        .sub_ack(sub_ack), .sub_done(sub_done), .sub_pw(sub_pw), .sub_gw(sub_gw), .sub_tmo(sub_tmo),
        .score_req(score_req), .score(score), .playerID(playerID), .isGuest(isGuest),
        .valid(valid), .personal_winner(personal_winner), .global_winner(global_winner),
        .ready(ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nchk = 0;
    int nerr = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s t=%0t got=%0h expected=%0h", nm, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int           cyc;
    logic [N-1:0] m_pend, old_pend;
    logic [6:0]   m_score [N];
    logic [2:0]   m_id    [N];
    logic         m_guest [N];
    int           m_ptr, m_init_left, m_busy, m_wait, m_c;
    logic [N-1:0] e_ack, e_done, e_pw, e_gw, e_tmo;
    logic         e_req, e_guest, e_ready;
    logic [6:0]   e_score;
    logic [2:0]   e_id;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            cyc = 0;
            m_pend = '0;
            for (int i = 0; i < N; i++) begin
                m_score[i] = '0; m_id[i] = '0; m_guest[i] = 1'b0;
            end
            m_ptr = N - 1; m_init_left = INIT_CYCLES; m_busy = -1; m_wait = 0;
            e_ack = '0; e_done = '0; e_pw = '0; e_gw = '0; e_tmo = '0;
            e_req = 1'b0; e_score = '0; e_id = '0; e_guest = 1'b0; e_ready = 1'b0;
        end else begin
            cyc++;
            old_pend = m_pend;
            e_ack = '0; e_done = '0; e_req = 1'b0;
            if (m_init_left > 0) begin
                m_init_left--;
            end else if (m_busy < 0) begin
                for (int k = 1; k <= N; k++) begin
                    m_c = (m_ptr + k) % N;
                    if (old_pend[m_c]) begin
                        m_busy = m_c; m_ptr = m_c; m_wait = 0; e_req = 1'b1;
                        e_score = m_score[m_c]; e_id = m_id[m_c]; e_guest = m_guest[m_c];
                        break;
                    end
                end
            end else begin
                m_wait++;
                if (valid) begin
                    e_pw[m_busy] = personal_winner; e_gw[m_busy] = global_winner;
                    e_tmo[m_busy] = 1'b0; e_done[m_busy] = 1'b1;
                    m_pend[m_busy] = 1'b0; m_busy = -1;
                end else if (m_wait == TIMEOUT) begin
                    e_pw[m_busy] = 1'b0; e_gw[m_busy] = 1'b0;
                    e_tmo[m_busy] = 1'b1; e_done[m_busy] = 1'b1;
                    m_pend[m_busy] = 1'b0; m_busy = -1;
                end
            end
            for (int i = 0; i < N; i++) begin
                if (sub_req[i] && !old_pend[i]) begin
                    m_pend[i] = 1'b1; e_ack[i] = 1'b1;
                    m_score[i] = sub_score[7*i +: 7];
                    m_id[i] = sub_id[3*i +: 3];
                    m_guest[i] = sub_guest[i];
                end
            end
            e_ready = (m_init_left == 0);
        end
    end

    always @(negedge clk) begin
        chk("sub_ack",   32'(sub_ack),   32'(e_ack));
        chk("sub_done",  32'(sub_done),  32'(e_done));
        chk("sub_pw",    32'(sub_pw),    32'(e_pw));
        chk("sub_gw",    32'(sub_gw),    32'(e_gw));
        chk("sub_tmo",   32'(sub_tmo),   32'(e_tmo));
        chk("score_req", 32'(score_req), 32'(e_req));
        chk("score",     32'(score),     32'(e_score));
        chk("playerID",  32'(playerID),  32'(e_id));
        chk("isGuest",   32'(isGuest),   32'(e_guest));
        chk("ready",     32'(ready),     32'(e_ready));
    end

    // ---------------- tracker stand-in ----------------
    int   tr_delay = 3;
    logic tr_mute  = 1'b0;
    logic tr_pw    = 1'b0;
    logic tr_gw    = 1'b0;
    int   spur_cnt = 0;
    int   spur_done = 0;
    int   cd = 0;

    always @(negedge clk or negedge rst) begin
        if (!rst) begin
            cd = 0; valid = 1'b0; personal_winner = 1'b0; global_winner = 1'b0;
        end else begin
            valid = 1'b0; personal_winner = 1'b0; global_winner = 1'b0;
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    valid = 1'b1; personal_winner = tr_pw; global_winner = tr_gw;
                end
            end
            if (score_req && !tr_mute) cd = tr_delay - 1;
            if (spur_cnt != spur_done) begin
                spur_done = spur_cnt;
                valid = 1'b1; personal_winner = 1'b1; global_winner = 1'b1;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_slot(input int st, input int sc, input int id, input logic g);
        sub_score[7*st +: 7] = sc[6:0];
        sub_id[3*st +: 3]    = id[2:0];
        sub_guest[st]        = g;
    endtask

    // Returns at the negedge following the sampling edge (cyc == sampling edge).
    task automatic strobe(input logic [N-1:0] m, output int s);
        sub_req = m;
        @(negedge clk);
        sub_req = '0;
        s = cyc;
    endtask

    task automatic wait_req(output int c);
        c = -1;
        for (int i = 0; i < 300; i++) begin
            if (score_req) begin
                c = cyc;
                break;
            end
            @(negedge clk);
        end
        if (c < 0) begin
            nchk++; nerr++;
            $display("FAIL wait_req no score_req within 300 cycles");
        end else begin
            @(negedge clk);
        end
    endtask

    task automatic wait_done(input int st, output int c);
        c = -1;
        for (int i = 0; i < 300; i++) begin
            if (sub_done[st]) begin
                c = cyc;
                break;
            end
            @(negedge clk);
        end
        if (c < 0) begin
            nchk++; nerr++;
            $display("FAIL wait_done station %0d no sub_done within 300 cycles", st);
        end else begin
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    int s, c, d, c1, d1;
    int rc [N];

    initial begin
        rst = 1'b1;
        sub_req = '0; sub_score = '0; sub_id = '0; sub_guest = '0;
        #1 rst = 1'b0;
        #1;
        chk("reset_outs", 32'({sub_ack, sub_done, sub_pw, sub_gw, sub_tmo, score_req, score, playerID, isGuest, ready}), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;

        // 1: early submission held off until the init hold ends
        while (cyc < 4) @(negedge clk);
        set_slot(0, 50, 2, 1'b0);
        tr_delay = 3; tr_pw = 1'b0; tr_gw = 1'b1;
        strobe(4'b0001, s);
        chk("t1_ack_hi", 32'(sub_ack), 32'h1);
        @(negedge clk);
        chk("t1_ack_lo", 32'(sub_ack), 32'h0);
        wait_req(c);
        chk("t1_req_cycle", 32'(c), 32'd37);
        chk("t1_score", 32'(score), 32'd50);
        chk("t1_id", 32'(playerID), 32'd2);
        wait_done(0, d);
        chk("t1_done_lat", 32'(d - c), 32'd3);
        chk("t1_gw0", 32'(sub_gw[0]), 32'd1);

        // 2: stray valid while idle, then a normal transaction for station 1
        spur_cnt++;
        repeat (2) @(negedge clk);
        set_slot(1, 33, 5, 1'b1);
        tr_pw = 1'b1; tr_gw = 1'b0;
        strobe(4'b0010, s);
        wait_req(c);
        chk("t2_req_lat", 32'(c - s), 32'd1);
        chk("t2_guest", 32'(isGuest), 32'd1);
        chk("t2_id", 32'(playerID), 32'd5);
        wait_done(1, d);
        chk("t2_done_lat", 32'(d - c), 32'd3);
        chk("t2_res", 32'({sub_pw[1], sub_gw[1], sub_tmo[1]}), 32'b100);
        strobe(4'b0010, s);
        chk("t2_reack", 32'(sub_ack), 32'h2);
        wait_done(1, d);
        strobe(4'b1000, s);
        wait_done(3, d);

        // 3: all four at once with ptr at N-1
        for (int i = 0; i < N; i++) set_slot(i, 10 + i, 4 + i, 1'b0);
        tr_delay = 2; tr_pw = 1'b1; tr_gw = 1'b1;
        strobe(4'b1111, s);
        chk("t3_ack", 32'(sub_ack), 32'hf);
        for (int j = 0; j < N; j++) begin
            wait_req(rc[j]);
            chk("t3_order_id", 32'(playerID), 32'(4 + j));
            chk("t3_order_score", 32'(score), 32'(10 + j));
            if (j > 0) chk("t3_gap", 32'(rc[j] - rc[j-1]), 32'd3);
        end
        wait_done(3, d);

        // 4: re-strobe while pending is ignored
        tr_delay = 5;
        set_slot(2, 77, 1, 1'b0);
        strobe(4'b0100, s);
        wait_req(c);
        chk("t4_req_lat", 32'(c - s), 32'd1);
        set_slot(2, 99, 6, 1'b1);
        strobe(4'b0100, s);
        chk("t4_no_ack", 32'(sub_ack), 32'h0);
        chk("t4_score", 32'(score), 32'd77);
        wait_done(2, d);
        chk("t4_score_hold", 32'(score), 32'd77);

        // 5: tracker silent, timeouts, next pending granted immediately
        tr_mute = 1'b1;
        set_slot(0, 40, 3, 1'b0);
        set_slot(1, 41, 6, 1'b0);
        strobe(4'b0011, s);
        wait_req(c);
        chk("t5_first_id", 32'(playerID), 32'd3);
        wait_done(0, d);
        chk("t5_tmo_lat", 32'(d - c), 32'd16);
        chk("t5_res0", 32'({sub_pw[0], sub_gw[0], sub_tmo[0]}), 32'b001);
        wait_req(c1);
        chk("t5_next_lat", 32'(c1 - d), 32'd1);
        chk("t5_next_id", 32'(playerID), 32'd6);
        wait_done(1, d1);
        chk("t5_tmo_lat1", 32'(d1 - c1), 32'd16);
        chk("t5_res1", 32'({sub_pw[1], sub_gw[1], sub_tmo[1]}), 32'b001);

        // 6: reset in the middle of a wait
        set_slot(2, 12, 2, 1'b0);
        strobe(4'b0100, s);
        wait_req(c);
        repeat (2) @(negedge clk);
        #3 rst = 1'b0;
        #1;
        chk("t6_async_outs", 32'({sub_ack, sub_done, sub_pw, sub_gw, sub_tmo, score_req, score, playerID, isGuest, ready}), 32'd0);
        tr_mute = 1'b0; tr_delay = 3;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        while (cyc < 4) @(negedge clk);
        set_slot(3, 21, 7, 1'b0);
        strobe(4'b1000, s);
        wait_req(c);
        chk("t6_req_cycle", 32'(c), 32'd37);
        chk("t6_id", 32'(playerID), 32'd7);
        wait_done(3, d);
        chk("t6_done_lat", 32'(d - c), 32'd3);
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
